// File: rtl/kogge_stone_arbiter.sv
// Round-robin arbiter sharing one combinational Kogge-Stone adder among NUM_REQ
// requesters, with a single-entry registered response buffer.

module kogge_stone_adder #(
    parameter int PRECISION = 8
) (
    input  logic [PRECISION-1:0] a_i,
    input  logic [PRECISION-1:0] b_i,
    output logic [PRECISION-1:0] sum_o,
    output logic                 cout_o
);
    localparam int LVL = (PRECISION > 1) ? $clog2(PRECISION) : 0;

    logic [PRECISION-1:0] w_p0;
    logic [PRECISION-1:0] w_g;
    logic [PRECISION-1:0] w_p;
    logic [PRECISION-1:0] w_g_n;
    logic [PRECISION-1:0] w_p_n;

    // Parallel-prefix carry tree: level l combines spans that are 2^l bits apart.
    always_comb begin
        w_p0  = a_i ^ b_i;
        w_g   = a_i & b_i;
        w_p   = w_p0;
        w_g_n = '0;
        w_p_n = '0;
        for (int l = 0; l < LVL; l++) begin
            w_g_n = w_g;
            w_p_n = w_p;
            for (int i = 0; i < PRECISION; i++) begin
                if (i >= (1 << l)) begin
                    w_g_n[i] = w_g[i] | (w_p[i] & w_g[i - (1 << l)]);
                    w_p_n[i] = w_p[i] & w_p[i - (1 << l)];
                end
            end
            w_g = w_g_n;
            w_p = w_p_n;
        end
    end

    // Carry-in is zero, so carry into bit i is the group generate of bits [i-1:0].
    always_comb begin
        sum_o    = '0;
        sum_o[0] = w_p0[0];
        for (int i = 1; i < PRECISION; i++) begin
            sum_o[i] = w_p0[i] ^ w_g[i-1];
        end
        cout_o = w_g[PRECISION-1];
    end
endmodule

module kogge_stone_arbiter #(
    parameter int PRECISION = 8,
    parameter int NUM_REQ   = 4
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [NUM_REQ-1:0]             req_valid_i,
    output logic [NUM_REQ-1:0]             req_ready_o,
    input  logic [NUM_REQ*PRECISION-1:0]   operand_a_i,
    input  logic [NUM_REQ*PRECISION-1:0]   operand_b_i,
    output logic                           rsp_valid_o,
    input  logic                           rsp_ready_i,
    output logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0] rsp_id_o,
    output logic [PRECISION-1:0]           result_o,
    output logic                           overflow_o
);
    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [ID_W-1:0]      r_prio;
    logic                 r_rsp_valid;
    logic [ID_W-1:0]      r_rsp_id;
    logic [PRECISION-1:0] r_result;
    logic                 r_overflow;

    logic                 w_can_accept;
    logic                 w_found;
    logic                 w_grant;
    logic [ID_W-1:0]      w_win;
    logic [ID_W-1:0]      w_prio_nxt;
    int                   w_pos;
    logic [PRECISION-1:0] w_a;
    logic [PRECISION-1:0] w_b;
    logic [PRECISION-1:0] w_sum;
    logic                 w_cout;

    assign w_can_accept = !r_rsp_valid | rsp_ready_i;

    // Scan from the far end of the search order back to prio so that the
    // last hit written is the first valid requester at or after prio.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_pos   = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_pos = int'(r_prio) + k;
            if (w_pos >= NUM_REQ) begin
                w_pos = w_pos - NUM_REQ;
            end
            if (req_valid_i[ID_W'(w_pos)]) begin
                w_found = 1'b1;
                w_win   = ID_W'(w_pos);
            end
        end
    end

    assign w_grant    = w_found & w_can_accept & !rst_i;
    assign w_prio_nxt = (w_win == ID_W'(NUM_REQ - 1)) ? '0 : w_win + 1'b1;

    always_comb begin
        req_ready_o = '0;
        if (w_grant) begin
            req_ready_o[w_win] = 1'b1;
        end
    end

    always_comb begin
        w_a = '0;
        w_b = '0;
        for (int r = 0; r < NUM_REQ; r++) begin
            if (ID_W'(r) == w_win) begin
                w_a = operand_a_i[r*PRECISION +: PRECISION];
                w_b = operand_b_i[r*PRECISION +: PRECISION];
            end
        end
    end

    kogge_stone_adder #(
        .PRECISION (PRECISION)
    ) u_adder (
        .a_i    (w_a),
        .b_i    (w_b),
        .sum_o  (w_sum),
        .cout_o (w_cout)
    );

    // A new grant overwrites the buffer even while it drains; data holds otherwise.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_prio      <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_result    <= '0;
            r_overflow  <= 1'b0;
        end else if (w_grant) begin
            r_prio      <= w_prio_nxt;
            r_rsp_valid <= 1'b1;
            r_rsp_id    <= w_win;
            r_result    <= w_sum;
            r_overflow  <= w_cout;
        end else if (rsp_ready_i) begin
            r_rsp_valid <= 1'b0;
        end
    end

    assign rsp_valid_o = r_rsp_valid;
    assign rsp_id_o    = r_rsp_id;
    assign result_o    = r_result;
    assign overflow_o  = r_overflow;
endmodule

// File: doc/kogge_stone_arbiter.md
# kogge_stone_arbiter

Round-robin arbiter that shares one combinational `kogge_stone_adder` instance among `NUM_REQ` requesters. Each requester presents an operand pair with a valid/ready handshake. The arbiter grants one requester per cycle and registers the sum, overflow and requester ID into a single-entry response buffer with its own valid/ready handshake. It sits between the issuing units and the shared adder datapath, giving fair, back-pressured access at up to one addition per cycle.

## Interface
Parameters:
- `PRECISION`, 8: operand/result width, passed to the internal adder.
- `NUM_REQ`, 4: number of requesters, 2..16.
- `ID_W`, derived as ceil(log2(NUM_REQ)), minimum 1: width of `rsp_id_o`. Not overridable.

Ports:
- `clk_i`  in  1  sole clock; all state updates on the rising edge.
- `rst_i`  in  1  synchronous, active-high reset.
- `req_valid_i`  in  NUM_REQ  per-requester request valid.
- `req_ready_o`  out  NUM_REQ  per-requester grant/accept; at most one bit high.
- `operand_a_i`  in  NUM_REQ*PRECISION  requester r's operand A is bits [r*PRECISION +: PRECISION].
- `operand_b_i`  in  NUM_REQ*PRECISION  requester r's operand B, same packing.
- `rsp_valid_o`  out  1  response buffer holds a result.
- `rsp_ready_i`  in  1  consumer accepts the response.
- `rsp_id_o`  out  ID_W  index of the requester that produced the response.
- `result_o`  out  PRECISION  registered sum, modulo 2^PRECISION.
- `overflow_o`  out  1  registered carry-out of the addition.

## Operation
- Acceptance condition: `can_accept = !rsp_valid_o | rsp_ready_i`, so the buffer is empty or draining this cycle.
- Arbitration is combinational and round-robin.
  - Pointer `prio` (ID_W bits) names the highest-priority requester.
  - The search order is prio, prio+1, …, wrapping modulo NUM_REQ.
  - The first requester with `req_valid_i` set wins.
- `req_ready_o[w]` = 1 only for winner `w`, and only when `can_accept` is 1. All other bits are 0.
- `req_ready_o` does not depend on `req_ready_o` itself. It may depend on `req_valid_i` and `rsp_ready_i` (the combinational path is allowed).
- A transfer occurs on requester w when `req_valid_i[w] & req_ready_o[w]`.
- On a transfer edge:
  - Buffer loads the adder output for requester w's operands: `result_o`, `overflow_o`.
  - `rsp_id_o` loads w; `rsp_valid_o` is set to 1.
  - `prio` loads (w+1) mod NUM_REQ.
- On an edge with response drain (`rsp_valid_o & rsp_ready_i`) and no transfer: `rsp_valid_o` is cleared. Data fields hold their last values.
- Drain and transfer in the same cycle: the new response replaces the old one and `rsp_valid_o` stays 1.
- With no valid request, or no `can_accept`, `prio` holds.
- Requester rules:
  - Once `req_valid_i[r]` is asserted, operands must stay stable until the transfer.
  - Deasserting valid before the grant is allowed. The arbiter keeps no per-requester state.
- Arithmetic: `result_o = (A + B) mod 2^PRECISION`; `overflow_o` = bit PRECISION of the unsigned sum.
- Fairness: a continuously valid requester is granted within NUM_REQ accepting cycles.

## Timing
- Reset (`rst_i`=1 at an edge):
  - Outputs: `rsp_valid_o`=0, `rsp_id_o`=0, `result_o`=0, `overflow_o`=0.
  - `prio`=0.
  - `req_ready_o` is all zero while `rst_i` is high.
- Latency: a request accepted at edge N appears on `rsp_valid_o`/`result_o` immediately after edge N.
- Throughput: one result per cycle while `rsp_ready_i` is held high.
- Back-pressure: `rsp_valid_o`=1 with `rsp_ready_i`=0 forces all `req_ready_o` to 0. The response holds stable until it is accepted.
- Reset mid-operation: any pending response is discarded, with no partial output. The first post-reset grant goes to the lowest-index valid requester.
- Wrap-around: `prio` advances from NUM_REQ-1 to 0. For non-power-of-two NUM_REQ, pointer values ≥ NUM_REQ never occur.
- The adder path (operand mux plus prefix tree) is one combinational stage between the request inputs and the response register.

## Test plan
- Reset and single request: after reset, requester 2 issues A=0x7F, B=0x01 with `rsp_ready_i`=1.
  - `req_ready_o`=4'b0100 that cycle.
  - Next cycle: `rsp_valid_o`=1, `rsp_id_o`=2, `result_o`=0x80, `overflow_o`=0; `prio`=3.
- Overflow: requester 0 issues A=0xFF, B=0x01 → `result_o`=0x00, `overflow_o`=1. A=0xC8, B=0x64 → 0x2C with `overflow_o`=1.
- Round-robin: all 4 requesters valid continuously, `rsp_ready_i`=1, starting from reset.
  - `rsp_id_o` sequence is 0,1,2,3,0,1… with one response per cycle.
  - No requester waits more than 4 cycles.
- Back-pressure: response pending with `rsp_ready_i`=0 for 3 cycles while requesters 1 and 3 are valid.
  - `req_ready_o`=0 and the response is stable through those cycles.
  - On the cycle `rsp_ready_i`=1, drain and new grant happen together and `rsp_valid_o` stays 1.
- Reset mid-stream: assert `rst_i` while `rsp_valid_o`=1 and `prio`=2.
  - Next cycle all outputs are 0.
  - The first grant after reset goes to the lowest valid index.
- Randomized-check directed sweep: exhaustive A,B in 0..255 through requester 1. Check `{overflow_o,result_o}` = A+B for all 65536 pairs.
